// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle (sclk/ss/mosi/miso) shared by an SPI master and spi_reg_slave.
interface spi_reg_slave_if;
    logic sclk_s;
    logic ss;
    logic mosi;
    logic miso;

    modport master (output sclk_s, output ss, output mosi, input miso);
    modport slave  (input sclk_s, input ss, input mosi, output miso);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-bank responder, all pins oversampled in clk_s.
// Define SPI_REG_AUTOINC_EN for burst access with address auto-increment.
module spi_reg_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_s,
    input  logic                  rst_n,
    spi_reg_slave_if.slave        spi,
    output logic                  wr_strobe,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] loc_addr,
    output logic [DATA_WIDTH-1:0] loc_data,
    output logic                  frame_err
);
    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_e;

    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic ss_meta_q, ss_sync_q, ss_dly_q;
    logic mosi_meta_q, mosi_sync_q;
    logic sclk_rise_d, sclk_rise_q, sclk_fall_d, sclk_fall_q;
    logic ss_rise_d, ss_rise_q, ss_fall_d, ss_fall_q;

    state_e                state_q, state_d, st_cur;
    logic [2:0]            cnt_q, cnt_d, cnt_cur;
    logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_next;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, cmd_addr;
    logic                  miso_q, miso_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] bank_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] bank_d [NUM_REGS];
`ifdef SPI_REG_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] addr_inc;
    assign addr_inc = addr_q + 1'b1;
`endif

    // ss syncs reset low so a select held low across reset release never looks like a frame start.
    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_dly_q  <= 1'b0;
            ss_meta_q   <= 1'b0;
            ss_sync_q   <= 1'b0;
            ss_dly_q    <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ss_rise_q   <= 1'b0;
            ss_fall_q   <= 1'b0;
        end else begin
            sclk_meta_q <= spi.sclk_s;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            ss_meta_q   <= spi.ss;
            ss_sync_q   <= ss_meta_q;
            ss_dly_q    <= ss_sync_q;
            mosi_meta_q <= spi.mosi;
            mosi_sync_q <= mosi_meta_q;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            ss_rise_q   <= ss_rise_d;
            ss_fall_q   <= ss_fall_d;
        end
    end

    always_comb begin
        sclk_rise_d = sclk_sync_q & ~sclk_dly_q;
        sclk_fall_d = ~sclk_sync_q & sclk_dly_q;
        ss_rise_d   = ss_sync_q & ~ss_dly_q;
        ss_fall_d   = ~ss_sync_q & ss_dly_q;
    end

    // An ss fall is applied before any same-cycle sclk rise, so that rise becomes bit 0.
    always_comb begin
        rx_next     = {rx_q[DATA_WIDTH-2:0], mosi_sync_q};
        cmd_addr    = rx_next[ADDR_WIDTH-1:0];
        st_cur      = ss_fall_q ? ST_CMD : state_q;
        cnt_cur     = ss_fall_q ? '0 : cnt_q;
        state_d     = st_cur;
        cnt_d       = cnt_cur;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        case (st_cur)
            ST_IDLE: miso_d = 1'b0;
            ST_CMD: begin
                if (sclk_rise_q) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_cur + 3'd1;
                    if (cnt_cur == 3'd7) begin
                        rw_d    = rx_next[DATA_WIDTH-1];
                        addr_d  = cmd_addr;
                        state_d = ST_DATA;
                        if (rx_next[DATA_WIDTH-1]) tx_d = bank_q[cmd_addr];
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise_q) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_cur + 3'd1;
                    if (cnt_cur == 3'd7) begin
                        if (!rw_q) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = rx_next;
                        end
`ifdef SPI_REG_AUTOINC_EN
                        addr_d = addr_inc;
                        if (rw_q) tx_d = bank_q[addr_inc];
`else
                        state_d = ST_DONE;
`endif
                    end
                end else if (sclk_fall_q && rw_q) begin
                    miso_d = tx_q[DATA_WIDTH-1];
                    tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            ST_DONE: miso_d = 1'b0;
            default: state_d = ST_IDLE;
        endcase
        if (ss_rise_q) begin
            state_d     = ST_IDLE;
            miso_d      = 1'b0;
            frame_err_d = ((state_q == ST_CMD) || (state_q == ST_DATA)) && (cnt_q != '0);
        end
    end

    // Bank update lags wr_strobe by one cycle so loc_data changes the cycle after the strobe.
    always_comb begin
        bank_d = bank_q;
        if (wr_strobe_q) bank_d[wr_addr_q] = wr_data_q;
    end

    always_ff @(posedge clk_s or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            bank_q      <= bank_d;
        end
    end

    assign spi.miso  = miso_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign loc_data  = bank_q[loc_addr];
endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: frame-level reference model feeds an expected-event queue.
module tb_spi_reg_slave;
    logic       clk_s = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] loc_addr;
    logic [7:0] loc_data;
    logic       frame_err;

`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int         kind;
        logic [3:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] model[16];
    int         checks = 0;
    int         passes = 0;

    spi_reg_slave_if spi ();

    spi_reg_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk_s    (clk_s),
        .rst_n    (rst_n),
        .spi      (spi),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .loc_addr (loc_addr),
        .loc_data (loc_data),
        .frame_err(frame_err)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic push_ev(input int kind, input logic [3:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    // Reference model: whole-frame semantics from command byte, byte count and leftover bits.
    task automatic model_frame(input logic [23:0] fr, input int nbits);
        int         nby;
        int         rem;
        logic [7:0] cmd;
        logic [7:0] db;
        logic [3:0] a;
        nby = nbits / 8;
        rem = nbits % 8;
        cmd = fr[23:16];
        for (int j = 1; j < nby; j++) begin
            db = 8'(fr >> (8 * (2 - j)));
            a  = cmd[3:0] + 4'(j - 1);
            if (j == 1 || AUTOINC) begin
                if (cmd[7]) push_ev(EV_RD, a, model[a]);
                else begin
                    push_ev(EV_WR, a, db);
                    model[a] = db;
                end
            end else if (cmd[7]) begin
                push_ev(EV_RD, 4'd0, 8'h00);
            end
        end
        if (rem != 0 && (nby <= 1 || AUTOINC)) push_ev(EV_ERR, 4'd0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, 32'(spi.miso), 32'd0);
        chk({tag, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_loc_data"}, 32'(loc_data), 32'd0);
    endtask

    // Mode-0 master; miso for data bit j is taken just before the sclk fall that ends bit j.
    task automatic run_frame(input logic [23:0] fr, input int nbits, input int h,
                             input bit fast, input int rst_at);
        logic [7:0] rxb;
        int         start;
        bit         rd;
        rd  = fr[23] && (rst_at < 0);
        rxb = 8'h00;
        if (fast) begin
            spi.mosi = fr[23];
            @(negedge clk_s);
            spi.ss     = 1'b0;
            spi.sclk_s = 1'b1;
            repeat (h) @(negedge clk_s);
            start = 1;
        end else begin
            spi.ss = 1'b0;
            repeat (2) @(negedge clk_s);
            start = 0;
        end
        for (int k = start; k < nbits; k++) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk_s);
                check_reset_outputs("midrst");
                for (int i = 0; i < 16; i++) model[i] = 8'h00;
                rst_n = 1'b1;
            end
            if (rd && k >= 9) begin
                rxb = {rxb[6:0], spi.miso};
                if ((k - 9) % 8 == 7) got_q.push_back(rxb);
            end
            spi.sclk_s = 1'b0;
            spi.mosi   = fr[23-k];
            repeat (h) @(negedge clk_s);
            spi.sclk_s = 1'b1;
            repeat (h) @(negedge clk_s);
        end
        if (rd && nbits >= 9) begin
            rxb = {rxb[6:0], spi.miso};
            if ((nbits - 9) % 8 == 7) got_q.push_back(rxb);
        end
        spi.sclk_s = 1'b0;
        repeat (h) @(negedge clk_s);
        spi.ss = 1'b1;
        repeat (8) @(negedge clk_s);
    endtask

    task automatic frame(input logic [23:0] fr, input int nbits, input int h, input bit fast);
        model_frame(fr, nbits);
        run_frame(fr, nbits, h, fast, -1);
    endtask

    task automatic loc_chk(input logic [3:0] a);
        loc_addr = a;
        @(negedge clk_s);
        chk($sformatf("loc_data[%0d]", a), 32'(loc_data), 32'(model[a]));
    endtask

    // Monitor: every DUT output event pops the next expected event.
    always @(negedge clk_s) begin
        ev_t        e;
        logic [7:0] g;
        if (rst_n) begin
            if (wr_strobe) begin
                if (exp_q.size() == 0) chk("unexpected_wr_strobe", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_event_kind", 32'(EV_WR), 32'(e.kind));
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                end
            end
            if (frame_err) begin
                if (exp_q.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("err_event_kind", 32'(EV_ERR), 32'(e.kind));
                end
            end
            if (got_q.size() != 0) begin
                g = got_q.pop_front();
                if (exp_q.size() == 0) chk("unexpected_read_byte", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("rd_event_kind", 32'(EV_RD), 32'(e.kind));
                    chk("rd_data", 32'(g), 32'(e.d));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cmd;
        logic [23:0] fr;
        int          nby;
        int          nbits;
        spi.sclk_s = 1'b0;
        spi.ss     = 1'b1;
        spi.mosi   = 1'b0;
        loc_addr   = 4'd0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk_s);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk_s);

        // Write then read back at sclk = clk_s/4.
        frame({8'h03, 8'hA5, 8'h00}, 16, 2, 1'b0);
        loc_chk(4'd3);
        frame({8'h83, 8'h00, 8'h00}, 16, 2, 1'b0);

        // Aborted frame, then a normal frame to the same register.
        frame({8'h05, 8'hF0, 8'h00}, 12, 3, 1'b0);
        loc_chk(4'd5);
        frame({8'h05, 8'h77, 8'h00}, 16, 3, 1'b0);
        loc_chk(4'd5);

        // Exactly eight command bits: no error, no write.
        frame({8'h06, 8'h00, 8'h00}, 8, 2, 1'b0);
        loc_chk(4'd6);

        // Reset in the middle of a write's data byte.
        run_frame({8'h02, 8'h99, 8'h00}, 16, 3, 1'b0, 12);
        loc_chk(4'd2);
        loc_chk(4'd3);
        frame({8'h02, 8'h3C, 8'h00}, 16, 3, 1'b0);
        loc_chk(4'd2);

        // Burst write across the top address.
        frame({8'h0F, 8'h11, 8'h22}, 24, 3, 1'b0);
        loc_chk(4'd15);
        loc_chk(4'd0);

        // Read at clk_s/4 plus a frame whose first sclk rise coincides with ss fall.
        frame({8'h0A, 8'h5A, 8'h00}, 16, 2, 1'b1);
        frame({8'h8A, 8'h00, 8'h00}, 16, 2, 1'b0);
        frame({8'h8F, 8'h00, 8'h00}, 24, 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            cmd   = {1'($urandom), 3'($urandom), 4'($urandom)};
            fr    = {cmd, 8'($urandom), 8'($urandom)};
            nby   = 1 + int'($urandom_range(1, 2));
            nbits = 8 * nby;
            if ($urandom_range(0, 4) == 0) nbits = int'($urandom_range(1, 8 * nby - 1));
            frame(fr, nbits, int'($urandom_range(2, 4)), $urandom_range(0, 3) == 0);
            if (n % 8 == 7) loc_chk(4'($urandom));
        end

        for (int i = 0; i < 16; i++) loc_chk(4'(i));
        repeat (20) @(negedge clk_s);
        chk("pending_expected_events", 32'(exp_q.size()), 32'd0);
        chk("pending_read_bytes", 32'(got_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
